phf_clear_engine: RTL and testbench
===================================

# phf_clear_engine

Responder side of the PHF clear handshake. Accepts `clear_req` from the PHF command handler, raises `busy` while it zero-fills the PHF hit buffer one word per cycle, then drops `busy` and reports buffer-clear status on `sts`. Outside a clear it passes datapath hit writes through to the buffer write port. During a clear it blocks hit writes and counts them.

## Interface
- `ADDR_W`, 10: buffer address width; DEPTH = 2**ADDR_W words.
- `DATA_W`, 32: buffer word width.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clear_req`  in  1  clear request level from the command handler; held high until `busy` is seen.
- `busy`  out  1  clear in progress.
- `sts`  out  1  1 = buffer is in the cleared state.
- `hit_wr`  in  1  datapath write strobe.
- `hit_addr`  in  ADDR_W  datapath write address.
- `hit_data`  in  DATA_W  datapath write data.
- `mem_wr_en`  out  1  buffer write enable (registered).
- `mem_addr`  out  ADDR_W  buffer write address (registered).
- `mem_data`  out  DATA_W  buffer write data (registered).
- `drop_cnt`  out  16  count of hit writes discarded during clears; saturating.

## Operation
- Reset (`rst`=1 at an edge): state S_IDLE. `busy`=0, `sts`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_data`=0, `drop_cnt`=0, internal address counter=0. This takes priority over everything, including mid-clear; an aborted clear leaves `sts`=0.
- States:
  - S_IDLE: `clear_req`=1 → S_CLEAR. Counter=0.
  - S_CLEAR: write zero at the counter address, then counter+1. After the write of address DEPTH-1: if `clear_req`=1 → S_DONE, else → S_IDLE. In both cases set `sts`=1.
  - S_DONE: `clear_req`=0 → S_IDLE. This state prevents a held request from retriggering.
- `busy` is a registered output and equals 1 exactly while in S_CLEAR.
- Write port, registered one cycle after inputs:
  - In S_CLEAR: `mem_wr_en`=1, `mem_addr`=counter, `mem_data`=0.
  - Otherwise: `mem_wr_en`=`hit_wr`, `mem_addr`=`hit_addr`, `mem_data`=`hit_data`.
- Hit handling:
  - `hit_wr`=1 while in S_CLEAR: dropped; `drop_cnt`+1, saturating at 0xFFFF and never wrapping.
  - `hit_wr`=1 in S_IDLE/S_DONE: accepted; clears `sts` on the same edge.
- Same edge as the final clear write with `hit_wr`=1: the hit is dropped (still S_CLEAR), and `sts` ends at 1.
- `drop_cnt` clears only on reset.
- Counter is ADDR_W+1 bits or uses an explicit last-address compare; the address never wraps within one clear.

## Timing
- Edge N samples `clear_req`=1 in S_IDLE. After edge N+1: `busy`=1, `mem_wr_en`=1, `mem_addr`=0. `busy` is therefore visible to the handler in the cycle following its S_CLEAR_REQ entry cycle.
- Writes occur on DEPTH consecutive cycles, addresses 0..DEPTH-1 ascending, no gaps.
- `busy` is high for exactly DEPTH cycles.
- `busy` falls and `sts` rises on the same edge, immediately after the last zero write is presented.
- Handler contract: `clear_req` drops no later than 1 cycle after `busy` rises. If it stays high, the engine parks in S_DONE with `busy`=0 and re-arms only after `clear_req`=0 is sampled.
- Pass-through latency: `hit_*` to `mem_*` is 1 cycle.

## Test plan
Use ADDR_W=4 (DEPTH=16).
- Reset then idle → `busy`=0, `sts`=0, `drop_cnt`=0, `mem_wr_en`=0. Hit write to addr 5, data 0xDEADBEEF → one cycle later `mem_wr_en`=1, `mem_addr`=5, `mem_data`=0xDEADBEEF.
- `clear_req` pulse, dropped 1 cycle after `busy` → `busy` high for exactly 16 cycles; `mem_addr` 0..15 in order with `mem_data`=0. Then `busy`=0, `sts`=1, state S_IDLE.
- `clear_req` held high throughout → one 16-cycle clear only. `busy` stays 0 afterwards until `clear_req` is lowered and raised again, which starts a second clear.
- 3 hit writes during a clear, including one on the last clear cycle → `drop_cnt`=3, none reach `mem_*`, `sts`=1 afterwards. A following accepted hit → `sts`=0.
- `rst` asserted at clear cycle 7 → next cycle `busy`=0, `mem_wr_en`=0, `sts`=0, `drop_cnt`=0. A new request restarts from address 0.
- `drop_cnt` forced near saturation (0xFFFE), then 4 dropped hits → `drop_cnt`=0xFFFF and no wrap.

Source files
------------

// File: rtl/phf_clear_engine.sv
`default_nettype none
// ============================================================================
// Module   : phf_clear_engine
// Brief    : PHF hit-buffer clear responder. Zero-fills the buffer one word
//            per cycle on request, otherwise passes datapath hit writes through.
// Revision : 1.0 - initial release
// ============================================================================
module phf_clear_engine #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    output logic              sts,
    input  logic              hit_wr,
    input  logic [ADDR_W-1:0] hit_addr,
    input  logic [DATA_W-1:0] hit_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [15:0]       drop_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic              r_sts;
    logic              r_mem_wr_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic [15:0]       r_drop_cnt;

    logic w_in_clear;
    logic w_last;
    logic w_hit_drop;
    logic w_hit_acc;
    logic w_drop_sat;

    assign w_in_clear = (r_state == S_CLEAR);
    assign w_last     = w_in_clear && (r_cnt == c_LAST_ADDR);
    assign w_hit_drop = hit_wr && w_in_clear;
    assign w_hit_acc  = hit_wr && !w_in_clear;
    assign w_drop_sat = &r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_sts       <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_drop_cnt  <= '0;
        end else begin
            // busy tracks the write port, so it lines up with the zero writes
            r_busy <= w_in_clear;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (clear_req) begin
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_cnt <= r_cnt + ADDR_W'(1);
                    if (w_last) begin
                        r_state <= clear_req ? S_DONE : S_IDLE;
                    end
                end
                S_DONE: begin
                    if (!clear_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_in_clear) begin
                r_mem_wr_en <= 1'b1;
                r_mem_addr  <= r_cnt;
                r_mem_data  <= '0;
            end else begin
                r_mem_wr_en <= hit_wr;
                r_mem_addr  <= hit_addr;
                r_mem_data  <= hit_data;
            end

            if (w_hit_drop && !w_drop_sat) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end

            // Status rises together with busy falling; a fresh accepted hit wins
            if (w_hit_acc) begin
                r_sts <= 1'b0;
            end else if (r_busy && !w_in_clear) begin
                r_sts <= 1'b1;
            end
        end
    end

    assign busy      = r_busy;
    assign sts       = r_sts;
    assign mem_wr_en = r_mem_wr_en;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_phf_clear_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_phf_clear_engine
// Brief    : Self-checking bench for phf_clear_engine with a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phf_clear_engine;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_req;
    logic          busy;
    logic          sts;
    logic          hit_wr;
    logic [AW-1:0] hit_addr;
    logic [DW-1:0] hit_data;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [15:0]   drop_cnt;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    phf_clear_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (busy),
        .sts       (sts),
        .hit_wr    (hit_wr),
        .hit_addr  (hit_addr),
        .hit_data  (hit_data),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Timeline model: a clear started at edge N owns edges N+1..N+DEPTH,
    // and its status lands on edge N+DEPTH+1.
    int            ecyc    = 0;
    int            m_start = 0;
    bit            m_act   = 1'b0;
    bit            m_park  = 1'b0;
    logic          e_busy  = 1'b0;
    logic          e_sts   = 1'b0;
    logic          e_we    = 1'b0;
    logic [AW-1:0] e_addr  = '0;
    logic [DW-1:0] e_data  = '0;
    logic [15:0]   e_drop  = '0;

    always @(posedge clk) begin
        int ph;
        bit in_clr;
        ecyc++;
        if (rst) begin
            m_act  = 1'b0;
            m_park = 1'b0;
            e_busy = 1'b0;
            e_sts  = 1'b0;
            e_we   = 1'b0;
            e_addr = '0;
            e_data = '0;
            e_drop = '0;
        end else begin
            ph     = ecyc - m_start;
            in_clr = m_act && (ph >= 1) && (ph <= DEPTH);
            e_busy = in_clr;
            if (in_clr) begin
                e_we   = 1'b1;
                e_addr = AW'(ph - 1);
                e_data = '0;
            end else begin
                e_we   = hit_wr;
                e_addr = hit_addr;
                e_data = hit_data;
            end
            if (hit_wr && in_clr) begin
                if (e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
            end else if (hit_wr) begin
                e_sts = 1'b0;
            end else if (m_act && ph == DEPTH + 1) begin
                e_sts = 1'b1;
            end
            if (m_act && ph == DEPTH) m_park = clear_req;
            else if (m_park && !clear_req) m_park = 1'b0;
            if (m_act && ph > DEPTH) m_act = 1'b0;
            if (!m_act && !m_park && clear_req) begin
                m_act   = 1'b1;
                m_start = ecyc;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            n_checks++;
            if ({busy, sts, mem_wr_en, mem_addr, mem_data, drop_cnt} !==
                {e_busy, e_sts, e_we, e_addr, e_data, e_drop}) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t got busy=%b sts=%b we=%b addr=%h data=%h drop=%h, expected busy=%b sts=%b we=%b addr=%h data=%h drop=%h",
                         $time, busy, sts, mem_wr_en, mem_addr, mem_data, drop_cnt,
                         e_busy, e_sts, e_we, e_addr, e_data, e_drop);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_busy(input logic val, input int lim, input string nm);
        int n = 0;
        while (busy !== val && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, busy}, {31'd0, val});
    endtask

    task automatic measure_clear(output int len, output int bad);
        len = 0;
        bad = 0;
        while (busy === 1'b1 && len < 40) begin
            if (mem_wr_en !== 1'b1 || mem_addr !== AW'(len) || mem_data !== '0) bad++;
            len++;
            @(negedge clk);
        end
    endtask

    task automatic run_clear(input int nhits);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            hit_wr   = (k <= nhits);
            hit_addr = AW'($urandom);
            hit_data = $urandom;
            @(negedge clk);
        end
        hit_wr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int bad;
        int cnt;
        rst       = 1'b1;
        clear_req = 1'b0;
        hit_wr    = 1'b0;
        hit_addr  = '0;
        hit_data  = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        rst    = 1'b0;

        // Reset state and pass-through
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sts", {31'd0, sts}, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("rst_we", {31'd0, mem_wr_en}, 32'd0);
        hit_wr   = 1'b1;
        hit_addr = 4'd5;
        hit_data = 32'hDEADBEEF;
        @(negedge clk);
        hit_wr = 1'b0;
        chk("pass_we", {31'd0, mem_wr_en}, 32'd1);
        chk("pass_addr", {28'd0, mem_addr}, 32'd5);
        chk("pass_data", mem_data, 32'hDEADBEEF);
        @(negedge clk);
        chk("pass_we_off", {31'd0, mem_wr_en}, 32'd0);

        // Pulsed request, dropped one cycle after busy
        clear_req = 1'b1;
        @(negedge clk);
        chk("pulse_busy_lat", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("pulse_busy_rise", {31'd0, busy}, 32'd1);
        clear_req = 1'b0;
        measure_clear(len, bad);
        chk("pulse_busy_len", len, DEPTH);
        chk("pulse_addr_seq", bad, 0);
        chk("pulse_sts", {31'd0, sts}, 32'd1);
        repeat (3) @(negedge clk);
        chk("pulse_idle", {31'd0, busy}, 32'd0);

        // Held request: one clear, park, then re-arm
        clear_req = 1'b1;
        @(negedge clk);
        wait_busy(1'b1, 4, "held_busy_rise");
        measure_clear(len, bad);
        chk("held_busy_len", len, DEPTH);
        chk("held_addr_seq", bad, 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy !== 1'b0) cnt++;
            @(negedge clk);
        end
        chk("held_no_retrigger", cnt, 0);
        clear_req = 1'b0;
        repeat (2) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        wait_busy(1'b1, 4, "rearm_busy_rise");
        clear_req = 1'b0;
        wait_busy(1'b0, 20, "rearm_busy_fall");

        // Three hits dropped during a clear, the last on its final write edge
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            hit_wr   = (k == 1 || k == 8 || k == DEPTH);
            hit_addr = AW'(k);
            hit_data = 32'h111 * k;
            @(negedge clk);
        end
        hit_wr = 1'b0;
        chk("drop_busy_done", {31'd0, busy}, 32'd0);
        chk("drop_cnt3", {16'd0, drop_cnt}, 32'd3);
        chk("drop_sts", {31'd0, sts}, 32'd1);
        hit_wr   = 1'b1;
        hit_addr = 4'd9;
        hit_data = 32'h12345678;
        @(negedge clk);
        hit_wr = 1'b0;
        chk("acc_sts_clear", {31'd0, sts}, 32'd0);
        chk("acc_data", mem_data, 32'h12345678);

        // Reset in the middle of a clear
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_we", {31'd0, mem_wr_en}, 32'd0);
        chk("abort_sts", {31'd0, sts}, 32'd0);
        chk("abort_drop", {16'd0, drop_cnt}, 32'd0);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        @(negedge clk);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_addr", {28'd0, mem_addr}, 32'd0);
        chk("restart_we", {31'd0, mem_wr_en}, 32'd1);
        wait_busy(1'b0, 20, "restart_busy_fall");

        // Drive drop_cnt up to saturation
        for (int c = 0; c < 4095; c++) run_clear(DEPTH);
        run_clear(14);
        chk("drop_fffe", {16'd0, drop_cnt}, 32'h0000FFFE);
        run_clear(4);
        chk("drop_ffff", {16'd0, drop_cnt}, 32'h0000FFFF);
        repeat (3) @(negedge clk);
        chk("drop_no_wrap", {16'd0, drop_cnt}, 32'h0000FFFF);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
